// File: rtl/psum_accum_drain.sv
// psum_accum_drain
//   Collects one psum per PE column per beat from the bottom row of the systolic
//   array and accumulates cfg_passes input-channel passes per output row. After
//   the final pass it drains the rows, one per beat, to the writeback stage.
//
// Optional feature macro: PSUM_SAT_EN
//   defined   : each drained lane is the accumulator clipped to the signed DATA_W
//               range, and sat_flag[c] marks a clipped lane.
//   undefined : each drained lane is the low DATA_W bits of the accumulator, and
//               sat_flag is tied to 0.
//
// Handshakes (both ports): a beat transfers on a rising clk edge where valid and
//   ready are both 1. A producer holds its payload stable while valid=1 and ready=0.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   start       1-cycle pulse in IDLE; samples cfg_rows / cfg_passes
//   cfg_rows    rows per tile (0 or >DEPTH means DEPTH)
//   cfg_passes  passes per tile (0 means 1)
//   in_valid    in_psum beat valid
//   in_ready    high only while accumulating
//   in_psum     N_COL lanes, lane c = bits [c*DATA_W +: DATA_W]
//   out_valid   drain beat valid (registered)
//   out_ready   consumer accepts the drain beat
//   out_data    N_COL narrowed accumulator lanes
//   out_row     row index of out_data
//   sat_flag    per-lane clip indication for the current beat
//   busy        FSM not idle
//   done        1-cycle pulse after the last drain handshake
module psum_accum_drain #(
   parameter int N_COL  = 4,
   parameter int DATA_W = 16,
   parameter int ACC_W  = 24,
   parameter int DEPTH  = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [$clog2(DEPTH):0]      cfg_rows,
   input  logic [7:0]                  cfg_passes,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N_COL*DATA_W-1:0]     in_psum,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [N_COL*DATA_W-1:0]     out_data,
   output logic [$clog2(DEPTH)-1:0]    out_row,
   output logic [N_COL-1:0]            sat_flag,
   output logic                        busy,
   output logic                        done
);

   localparam int RW = $clog2(DEPTH);
   localparam logic [RW:0]   DEPTH_L = (RW+1)'(DEPTH);
   localparam logic [RW-1:0] ROW_MAX = RW'(DEPTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]      state;
   logic [RW-1:0]   row;
   logic [RW-1:0]   rows_m1;
   logic [7:0]      pass;
   logic [7:0]      passes_m1;
   logic [ACC_W-1:0] acc [DEPTH][N_COL];

   logic accept;
   logic drain_hs;

   assign in_ready = (state == S_ACCUM);
   assign busy     = (state != S_IDLE);
   assign accept   = in_valid && in_ready;
   assign drain_hs = out_valid && out_ready;

   // Accumulator RAM: no reset, rows are always overwritten by pass 0 before
   // they can be drained, so stale contents never reach the output.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int c = 0; c < N_COL; c++) begin
            if (pass == 8'd0)
               acc[row][c] <= {{(ACC_W-DATA_W){in_psum[c*DATA_W+DATA_W-1]}},
                               in_psum[c*DATA_W +: DATA_W]};
            else
               acc[row][c] <= acc[row][c] +
                              {{(ACC_W-DATA_W){in_psum[c*DATA_W+DATA_W-1]}},
                               in_psum[c*DATA_W +: DATA_W]};
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         row       <= '0;
         rows_m1   <= '0;
         pass      <= '0;
         passes_m1 <= '0;
         out_valid <= 1'b0;
         out_row   <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_ACCUM;
                  row   <= '0;
                  pass  <= '0;
                  if (cfg_rows == '0 || cfg_rows > DEPTH_L)
                     rows_m1 <= ROW_MAX;
                  else
                     rows_m1 <= RW'(cfg_rows - 1'b1);
                  passes_m1 <= (cfg_passes == 8'd0) ? 8'd0 : cfg_passes - 8'd1;
               end
            end
            S_ACCUM: begin
               if (accept) begin
                  if (row == rows_m1) begin
                     row <= '0;
                     if (pass == passes_m1) begin
                        pass      <= '0;
                        state     <= S_DRAIN;
                        out_valid <= 1'b1;
                        out_row   <= '0;
                     end else begin
                        pass <= pass + 8'd1;
                     end
                  end else begin
                     row <= row + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (drain_hs) begin
                  if (out_row == rows_m1) begin
                     state     <= S_IDLE;
                     out_valid <= 1'b0;
                     out_row   <= '0;
                     done      <= 1'b1;
                  end else begin
                     out_row <= out_row + 1'b1;
                  end
               end
            end
            default: begin
               state     <= S_IDLE;
               out_valid <= 1'b0;
               out_row   <= '0;
            end
         endcase
      end
   end

   // Drain lanes are read straight from the RAM at out_row. The RAM is not
   // written during DRAIN, so the payload is stable under backpressure, and it
   // is forced to 0 whenever no beat is being offered.
`ifdef PSUM_SAT_EN
   always_comb begin
      out_data = '0;
      sat_flag = '0;
      if (out_valid) begin
         for (int c = 0; c < N_COL; c++) begin
            // The value fits in DATA_W bits only if every bit above the DATA_W
            // sign bit is a copy of it.
            if (acc[out_row][c][ACC_W-1:DATA_W-1] !=
                {(ACC_W-DATA_W+1){acc[out_row][c][ACC_W-1]}}) begin
               sat_flag[c] = 1'b1;
               out_data[c*DATA_W +: DATA_W] = acc[out_row][c][ACC_W-1] ?
                  {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
               out_data[c*DATA_W +: DATA_W] = acc[out_row][c][DATA_W-1:0];
            end
         end
      end
   end
`else
   always_comb begin
      out_data = '0;
      if (out_valid) begin
         for (int c = 0; c < N_COL; c++)
            out_data[c*DATA_W +: DATA_W] = acc[out_row][c][DATA_W-1:0];
      end
   end
   assign sat_flag = '0;
`endif

endmodule

// File: tb/tb_psum_accum_drain.sv
// tb_psum_accum_drain
//   Randomized and directed tiles for psum_accum_drain. A reference model sums
//   the issued beats per row with plain integer arithmetic and pushes the
//   expected drain beats into exp_q; a monitor pops and compares on every
//   drain handshake.
module tb_psum_accum_drain;
   localparam int N_COL  = 4;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 8;
   localparam int RW     = 3;
   localparam int EW     = RW + N_COL*DATA_W + N_COL;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [RW:0]       cfg_rows = '0;
   logic [7:0]        cfg_passes = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [63:0]       in_psum = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [63:0]       out_data;
   logic [RW-1:0]     out_row;
   logic [3:0]        sat_flag;
   logic              busy;
   logic              done;

   int n_tests = 0;
   int n_fail = 0;
   int done_cnt = 0;
   logic hold_ready = 1'b0;
   logic [EW-1:0] exp_q[$];
   logic [63:0]   beats[$];

   // clock / reset
   always #5 clk = ~clk;

   psum_accum_drain #(.N_COL(N_COL), .DATA_W(DATA_W), .ACC_W(24), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .cfg_rows(cfg_rows),
      .cfg_passes(cfg_passes), .in_valid(in_valid), .in_ready(in_ready),
      .in_psum(in_psum), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_row(out_row), .sat_flag(sat_flag),
      .busy(busy), .done(done)
   );

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // consumer: random out_ready, forced low while hold_ready is set
   initial begin
      forever begin
         @(posedge clk);
         #2;
         out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_drain_beat", {out_row, out_data, sat_flag}, '0);
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("drain_beat", {out_row, out_data, sat_flag}, e);
         end
      end else if (!out_valid) begin
         check("idle_outputs_zero", {out_row, out_data, sat_flag}, '0);
      end
   end

   // reference model: per-row integer sums, wrapped to 24 bits, then narrowed
   task automatic push_expected(input int er, input int ep);
      longint sum [DEPTH][N_COL];
      int idx = 0;
      for (int r = 0; r < DEPTH; r++)
         for (int c = 0; c < N_COL; c++) sum[r][c] = 0;
      for (int p = 0; p < ep; p++) begin
         for (int r = 0; r < er; r++) begin
            logic [63:0] b;
            b = beats[idx];
            idx++;
            for (int c = 0; c < N_COL; c++) begin
               logic [15:0] lane;
               int v;
               lane = b[c*16 +: 16];
               v = $signed(lane);
               sum[r][c] += v;
            end
         end
      end
      for (int r = 0; r < er; r++) begin
         logic [63:0] d;
         logic [3:0]  s;
         d = '0;
         s = '0;
         for (int c = 0; c < N_COL; c++) begin
            longint t;
            logic [23:0] w;
            int sv;
            t = sum[r][c];
            w = t[23:0];
            sv = $signed(w);
`ifdef PSUM_SAT_EN
            if (sv > 32767) begin
               d[c*16 +: 16] = 16'h7FFF;
               s[c] = 1'b1;
            end else if (sv < -32768) begin
               d[c*16 +: 16] = 16'h8000;
               s[c] = 1'b1;
            end else begin
               d[c*16 +: 16] = sv[15:0];
            end
`else
            d[c*16 +: 16] = sv[15:0];
`endif
         end
         exp_q.push_back({RW'(r), d, s});
      end
   endtask

   task automatic gen_random(input int n);
      beats.delete();
      for (int i = 0; i < n; i++) begin
         logic [63:0] b;
         for (int c = 0; c < N_COL; c++) begin
            case ($urandom_range(0, 3))
               0:       b[c*16 +: 16] = 16'h7000 + 16'($urandom_range(0, 255));
               1:       b[c*16 +: 16] = 16'h8800 - 16'($urandom_range(0, 255));
               default: b[c*16 +: 16] = 16'($urandom_range(0, 65535));
            endcase
         end
         beats.push_back(b);
      end
   endtask

   // driver tasks: each starts and ends 1 time unit after a rising edge
   task automatic do_start(input int rows, input int passes);
      cfg_rows = 4'(rows);
      cfg_passes = 8'(passes);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cfg_rows = 4'($urandom_range(1, 15));
      cfg_passes = 8'($urandom_range(1, 255));
      check("start_busy", busy, 1);
      check("start_in_ready", in_ready, 1);
   endtask

   task automatic send_beat(input logic [63:0] d);
      bit accepted = 0;
      int gap = $urandom_range(0, 2);
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_psum = d;
      for (int k = 0; k < 50 && !accepted; k++) begin
         logic rdy;
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         if (rdy) accepted = 1;
      end
      in_valid = 1'b0;
      in_psum = 64'($urandom());
      check("beat_accepted", accepted, 1);
   endtask

   task automatic run_tile(input int rows_cfg, input int passes_cfg, input bit poke, input bit bp);
      int er = (rows_cfg == 0 || rows_cfg > DEPTH) ? DEPTH : rows_cfg;
      int ep = (passes_cfg == 0) ? 1 : passes_cfg;
      int base;
      int k = 0;
      if (beats.size() == 0) gen_random(er * ep);
      push_expected(er, ep);
      base = done_cnt;
      hold_ready = bp;
      do_start(rows_cfg, passes_cfg);
      for (int i = 0; i < er * ep; i++) begin
         if (i == er * ep - 1) check("no_out_valid_before_last", out_valid, 0);
         send_beat(beats[i]);
      end
      check("latency_out_valid", out_valid, 1);
      check("latency_out_row", out_row, 0);
      check("drain_in_ready_low", in_ready, 0);
      if (bp) begin
         repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_hold_payload", {out_row, out_data, sat_flag}, exp_q[0]);
            check("bp_hold_valid", out_valid, 1);
         end
         check("bp_nothing_popped", exp_q.size(), er);
         hold_ready = 1'b0;
      end
      if (poke) begin
         start = 1'b1;
         cfg_rows = 4'd1;
         cfg_passes = 8'd1;
         in_valid = 1'b1;
         in_psum = 64'($urandom());
         @(posedge clk);
         #1;
         start = 1'b0;
         in_valid = 1'b0;
         check("poke_busy", busy, 1);
         check("poke_in_ready", in_ready, 0);
      end
      while ((busy || exp_q.size() != 0) && k < 3000) begin
         @(posedge clk);
         #1;
         k++;
      end
      @(posedge clk);
      #1;
      check("drain_complete", exp_q.size(), 0);
      check("done_once", done_cnt - base, 1);
      check("idle_after", busy, 0);
      exp_q.delete();
      beats.delete();
   endtask

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", {busy, in_ready, out_valid, done, out_row, out_data, sat_flag}, '0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // reset mid-ACCUM, then a fresh tile drains only new data
      do_start(4, 1);
      gen_random(2);
      send_beat(beats[0]);
      send_beat(beats[1]);
      reset = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      beats.delete();
      run_tile(2, 1, 0, 0);

      // rows=2, passes=3
      beats.delete();
      repeat (3) begin
         beats.push_back(64'h0010);
         beats.push_back(64'h0001);
      end
      run_tile(2, 3, 0, 0);

      // large positive lane0
      beats.delete();
      beats.push_back(64'h7000);
      beats.push_back(64'h7000);
      run_tile(1, 2, 0, 0);

      // negative lane1
      beats.delete();
      beats.push_back(64'hFFFE_0000);
      beats.push_back(64'hFFFE_0000);
      run_tile(1, 2, 0, 0);

      // backpressure
      run_tile(4, 2, 0, 1);

      // default rows/passes with start/in_valid poked during DRAIN
      run_tile(0, 0, 1, 0);

      // random tiles
      repeat (12) run_tile($urandom_range(0, 10), $urandom_range(0, 4), 0, $urandom_range(0, 3) == 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
